// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - Shared types and LED bit positions for the LED status scheduler
package led_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } led_state_e;

    localparam int NLED   = 3;
    localparam int LED1_B = 0;
    localparam int LED2_B = 1;
    localparam int LED3_B = 2;

endpackage

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - Free-running prescaler producing a one-cycle tick every TICK_DIV clocks
module led_tick_gen #(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int              CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/led_status_sched.sv
// rtl/led_status_sched.sv - Round-robin time-sharing of three status LEDs between NREQ sources
// Optional idle heartbeat on led1 when HEARTBEAT_EN is defined.
module led_status_sched
    import led_pkg::*;
#(
    parameter int TICK_DIV  = 1_000_000,
    parameter int NREQ      = 4,
    parameter int PAT_W     = 8,
    parameter int GAP_TICKS = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*PAT_W-1:0]   pat,
    input  logic [NREQ*NLED-1:0]    mask,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic                    led1,
    output logic                    led2,
    output logic                    led3
);

    localparam int            SW        = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int            GW        = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam int            RW        = $clog2(NREQ);
    localparam logic [SW-1:0] LAST_STEP = SW'(PAT_W - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_TICKS - 1);

    logic              tick;
    led_state_e        state_q, state_d;
    logic [SW-1:0]     step_q, step_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [RW-1:0]     rr_q, rr_d;
    logic [RW-1:0]     owner_q, owner_d;
    logic [PAT_W-1:0]  pat_r_q, pat_r_d;
    logic [NLED-1:0]   mask_r_q, mask_r_d;
    logic [NLED-1:0]   leds_q, leds_d;
    logic [2*NREQ-1:0] req_rot;
    logic [RW-1:0]     win;
    logic              win_vld;
    logic              show_end;

    led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Rotate requests so bit 0 is the rr pointer; lowest set bit wins.
    always_comb begin
        req_rot = {req, req} >> rr_q;
        win     = rr_q;
        win_vld = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                win     = RW'((int'(rr_q) + k) % NREQ);
                win_vld = 1'b1;
            end
        end
    end

    assign show_end = tick && (step_q == LAST_STEP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            step_q   <= '0;
            gap_q    <= '0;
            rr_q     <= '0;
            owner_q  <= '0;
            pat_r_q  <= '0;
            mask_r_q <= '0;
            leds_q   <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            gap_q    <= gap_d;
            rr_q     <= rr_d;
            owner_q  <= owner_d;
            pat_r_q  <= pat_r_d;
            mask_r_q <= mask_r_d;
            leds_q   <= leds_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        gap_d    = gap_q;
        rr_d     = rr_q;
        owner_d  = owner_q;
        pat_r_d  = pat_r_q;
        mask_r_d = mask_r_q;
        case (state_q)
            IDLE: begin
                if (tick && win_vld) begin
                    state_d = SHOW;
                    step_d  = '0;
                    owner_d = win;
                    rr_d    = (win == RW'(NREQ - 1)) ? '0 : win + RW'(1);
                    for (int i = 0; i < NREQ; i++) begin
                        if (win == RW'(i)) begin
                            pat_r_d  = pat[i*PAT_W +: PAT_W];
                            mask_r_d = mask[i*NLED +: NLED];
                        end
                    end
                end
            end
            SHOW: begin
                if (show_end) begin
                    state_d = GAP;
                    gap_d   = '0;
                end else if (tick) begin
                    step_d = step_q + SW'(1);
                end
            end
            GAP: begin
                if (tick) begin
                    if (gap_q == GAP_LAST) begin
                        state_d = IDLE;
                        gap_d   = '0;
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef HEARTBEAT_EN
    logic [3:0] hb_q, hb_d;

    always_comb begin
        hb_d = tick ? hb_q + 4'd1 : hb_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hb_q <= '0;
        end else begin
            hb_q <= hb_d;
        end
    end
`endif

    always_comb begin
        busy   = (state_q != IDLE);
        leds_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt[i] = (state_q == SHOW) && (owner_q == RW'(i));
        end
        case (state_q)
            SHOW: begin
                if (!show_end) begin
                    leds_d = pat_r_q[step_q] ? mask_r_q : '0;
                end
            end
`ifdef HEARTBEAT_EN
            IDLE: begin
                if (!(tick && win_vld)) begin
                    leds_d[LED1_B] = hb_q[3];
                end
            end
`endif
            default: leds_d = '0;
        endcase
    end

    assign led1 = leds_q[LED1_B];
    assign led2 = leds_q[LED2_B];
    assign led3 = leds_q[LED3_B];

endmodule
